// File: rtl/tile_kstream_feeder.sv
// Streams one k-slice per beat (W column + X row) from a loaded tile pair to the MAC array.
// The output stage is registered and uses a valid/ready handshake.
module tile_kstream_feeder #(
    parameter int unsigned M      = 8,
    parameter int unsigned N      = 8,
    parameter int unsigned KMAX   = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_done,
    input  logic [15:0]                K_len,
    input  logic [M*KMAX*DATA_W-1:0]   W_tile_flat,
    input  logic [KMAX*N*DATA_W-1:0]   X_tile_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [M*DATA_W-1:0]        out_w_col,
    output logic [N*DATA_W-1:0]        out_x_row,
    output logic [K_W-1:0]             out_k,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    // Wide enough to hold KMAX itself, not just KMAX-1.
    localparam int unsigned KE_W = $clog2(KMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [KE_W-1:0]        keff_q, keff_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [M*DATA_W-1:0]    w_col_q, w_col_d;
    logic [N*DATA_W-1:0]    x_row_q, x_row_d;

    logic [KE_W-1:0]        keff_c;
    logic [K_W-1:0]         k_inc_c;
    logic [K_W-1:0]         k_sel_c;
    logic [M*DATA_W-1:0]    slice_w_c;
    logic [N*DATA_W-1:0]    slice_x_c;
    logic                   xfer_c;

    assign keff_c  = (32'(K_len) >= KMAX) ? KE_W'(KMAX) : KE_W'(K_len);
    assign k_inc_c = (k_q == K_W'(KMAX - 1)) ? '0 : k_q + K_W'(1);
    assign k_sel_c = (state_q == S_IDLE) ? '0 : k_inc_c;
    assign xfer_c  = out_valid_q && out_ready;

    // Combinational slice select at the k about to be registered.
    always_comb begin
        slice_w_c = '0;
        slice_x_c = '0;
        for (int m = 0; m < int'(M); m++) begin
            slice_w_c[m*DATA_W +: DATA_W] =
                W_tile_flat[((m * int'(KMAX)) + int'(k_sel_c)) * DATA_W +: DATA_W];
        end
        for (int n = 0; n < int'(N); n++) begin
            slice_x_c[n*DATA_W +: DATA_W] =
                X_tile_flat[((int'(k_sel_c) * int'(N)) + n) * DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        keff_d      = keff_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        w_col_d     = w_col_q;
        x_row_d     = x_row_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (load_done) begin
                    keff_d = keff_c;
                    if (keff_c == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_STREAM;
                        k_d         = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = (keff_c == KE_W'(1));
                        busy_d      = 1'b1;
                        w_col_d     = slice_w_c;
                        x_row_d     = slice_x_c;
                    end
                end
            end
            S_STREAM: begin
                busy_d = 1'b1;
                if (xfer_c) begin
                    if (out_last_q) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        k_d        = k_inc_c;
                        out_last_d = ((KE_W'(k_inc_c) + KE_W'(1)) == keff_q);
                        w_col_d    = slice_w_c;
                        x_row_d    = slice_x_c;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            keff_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_col_q     <= '0;
            x_row_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            keff_q      <= keff_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_col_q     <= w_col_d;
            x_row_q     <= x_row_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_w_col = w_col_q;
    assign out_x_row = x_row_q;
    assign out_k     = k_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tile_kstream_feeder.sv
// Randomized bench for tile_kstream_feeder with a queue-based beat model and per-cycle compare.
module tb_tile_kstream_feeder;

    localparam int unsigned M    = 2;
    localparam int unsigned N    = 2;
    localparam int unsigned KMAX = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned K_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   load_done = 1'b0;
    logic [15:0]            K_len = '0;
    logic [M*KMAX*DW-1:0]   w_flat = '0;
    logic [KMAX*N*DW-1:0]   x_flat = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [M*DW-1:0]        out_w_col;
    logic [N*DW-1:0]        out_x_row;
    logic [K_W-1:0]         out_k;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    tile_kstream_feeder #(.M(M), .N(N), .KMAX(KMAX), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .load_done(load_done), .K_len(K_len),
        .W_tile_flat(w_flat), .X_tile_flat(x_flat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w_col(out_w_col), .out_x_row(out_x_row), .out_k(out_k),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] wt [M][KMAX];
    logic [DW-1:0] xt [KMAX][N];

    // Model: queue of k indices still to be delivered, plus a pending done pulse.
    int  q[$];
    int  m_keff = 0;
    bit  done_due = 1'b0;
    int  beat_cnt = 0;
    int  done_cnt = 0;
    int  busy_cnt = 0;
    int  last_k = -1;
    bit  rnd_ready = 1'b0;
    bit  rnd_load = 1'b0;

    bit                prev_stall = 1'b0;
    logic [M*DW-1:0]   prev_w;
    logic [N*DW-1:0]   prev_x;
    logic [K_W-1:0]    prev_k;
    logic              prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack_tiles();
        for (int m = 0; m < int'(M); m++)
            for (int k = 0; k < int'(KMAX); k++)
                w_flat[((m*KMAX)+k)*DW +: DW] = wt[m][k];
        for (int k = 0; k < int'(KMAX); k++)
            for (int n = 0; n < int'(N); n++)
                x_flat[((k*N)+n)*DW +: DW] = xt[k][n];
    endtask

    task automatic plan_tiles();
        for (int m = 0; m < int'(M); m++)
            for (int k = 0; k < int'(KMAX); k++)
                wt[m][k] = DW'(32'h100 * m + k);
        for (int k = 0; k < int'(KMAX); k++)
            for (int n = 0; n < int'(N); n++)
                xt[k][n] = DW'(32'h200 + 32'h10 * k + n);
        pack_tiles();
    endtask

    task automatic rand_tiles();
        for (int m = 0; m < int'(M); m++)
            for (int k = 0; k < int'(KMAX); k++)
                wt[m][k] = $urandom;
        for (int k = 0; k < int'(KMAX); k++)
            for (int n = 0; n < int'(N); n++)
                xt[k][n] = $urandom;
        pack_tiles();
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [M*DW-1:0] ew;
        logic [N*DW-1:0] ex;
        bit exp_valid, idle;
        int k, kl;
        if (!rst_n) begin
            chk("reset_outputs",
                {out_valid, busy, done, out_last, 58'(out_k), 2'b00},
                64'h0);
            chk("reset_data", out_w_col | out_x_row, 64'h0);
            q.delete();
            done_due   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_valid = (q.size() > 0);
            chk("valid", 64'(out_valid), 64'(exp_valid));
            chk("busy", 64'(busy), 64'(exp_valid));
            chk("done", 64'(done), 64'(done_due));
            k = exp_valid ? q[0] : 0;
            if (exp_valid) begin
                for (int m = 0; m < int'(M); m++) ew[m*DW +: DW] = wt[m][k];
                for (int n = 0; n < int'(N); n++) ex[n*DW +: DW] = xt[k][n];
                chk("out_k", 64'(out_k), 64'(k));
                chk("out_last", 64'(out_last), 64'(k == m_keff - 1));
                chk("w_col", 64'(out_w_col), 64'(ew));
                chk("x_row", 64'(out_x_row), 64'(ex));
            end
            if (prev_stall) begin
                chk("hold_w", 64'(out_w_col), 64'(prev_w));
                chk("hold_x", 64'(out_x_row), 64'(prev_x));
                chk("hold_k_last", 64'({prev_k, prev_last}), 64'({out_k, out_last}));
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            idle       = !exp_valid && !done_due;
            prev_stall = out_valid && !out_ready;
            prev_w     = out_w_col;
            prev_x     = out_x_row;
            prev_k     = out_k;
            prev_last  = out_last;
            done_due   = 1'b0;
            if (exp_valid && out_ready) begin
                beat_cnt++;
                last_k = k;
                void'(q.pop_front());
                if (q.size() == 0) done_due = 1'b1;
            end
            if (load_done && idle) begin
                kl = int'(K_len);
                m_keff = (kl > int'(KMAX)) ? int'(KMAX) : kl;
                if (m_keff == 0) done_due = 1'b1;
                for (int i = 0; i < m_keff; i++) q.push_back(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int klen);
        step();
        load_done = 1'b1;
        K_len     = 16'(klen);
        step();
        load_done = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin
            step();
            n++;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd_load) begin
                load_done = ($urandom_range(0, 7) == 0);
                K_len     = 16'($urandom);
            end
        end
        load_done = 1'b0;
        out_ready = 1'b1;
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL done_timeout: actual=no done required=done within 300 cycles");
        end
    endtask

    initial begin
        int b0, d0, u0;
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        plan_tiles();
        #12;
        chk("reset_valid_lit", 64'(out_valid), 64'h0);
        rst_n = 1'b1;
        step();

        // Plan stream, always ready
        b0 = beat_cnt; d0 = done_cnt; u0 = busy_cnt;
        pulse_load(3);
        chk("first_latency_valid", 64'(out_valid), 64'h1);
        step();
        chk("k1_lit", 64'(out_k), 64'h1);
        chk("k1_w_col_lit", 64'(out_w_col), 64'h00000101_00000001);
        chk("k1_x_row_lit", 64'(out_x_row), 64'h00000211_00000210);
        wait_done(d0);
        chk("t1_beats", 64'(beat_cnt - b0), 64'd3);
        chk("t1_dones", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy_cycles", 64'(busy_cnt - u0), 64'd3);
        chk("t1_last_k", 64'(last_k), 64'd2);

        // Stalled stream with fixed ready pattern
        b0 = beat_cnt; d0 = done_cnt;
        pulse_load(3);
        out_ready = pat[0][0];
        for (int i = 1; i < 6; i++) begin
            step();
            out_ready = pat[i][0];
        end
        wait_done(d0);
        chk("t2_beats", 64'(beat_cnt - b0), 64'd3);

        // Zero length
        b0 = beat_cnt; d0 = done_cnt; u0 = busy_cnt;
        pulse_load(0);
        chk("k0_done_lit", 64'(done), 64'h1);
        wait_done(d0);
        chk("k0_beats", 64'(beat_cnt - b0), 64'd0);
        chk("k0_busy", 64'(busy_cnt - u0), 64'd0);

        // Clamp to KMAX
        b0 = beat_cnt; d0 = done_cnt;
        pulse_load(9);
        wait_done(d0);
        chk("clamp_beats", 64'(beat_cnt - b0), 64'd4);
        chk("clamp_last_k", 64'(last_k), 64'd3);

        // Spurious load_done mid-stream
        b0 = beat_cnt; d0 = done_cnt;
        pulse_load(3);
        step();
        load_done = 1'b1;
        K_len = 16'd1;
        step();
        load_done = 1'b0;
        wait_done(d0);
        chk("respur_beats", 64'(beat_cnt - b0), 64'd3);
        chk("respur_dones", 64'(done_cnt - d0), 64'd1);

        // Reset mid-stream while stalled
        pulse_load(3);
        step();
        out_ready = 1'b0;
        step();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_async_lit", 64'({out_valid, busy, 2'(out_k)}), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        b0 = beat_cnt; d0 = done_cnt;
        pulse_load(2);
        wait_done(d0);
        chk("post_rst_beats", 64'(beat_cnt - b0), 64'd2);

        // Randomized streams, random back-pressure and spurious loads
        rnd_ready = 1'b1;
        rnd_load  = 1'b1;
        for (int it = 0; it < 30; it++) begin
            rand_tiles();
            d0 = done_cnt;
            pulse_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 65535))
                                                   : int'($urandom_range(0, 5)));
            out_ready = 1'($urandom_range(0, 1));
            wait_done(d0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
